// File: rtl/commit_unit_pkg.sv
// Shared widths, instruction-class ranges, FSM encoding and read-port type for the commit unit.
// Included first so every other file can import it.
package commit_unit_pkg;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;
  localparam int REG_W  = 5;
  localparam int REG_N  = 32;
  localparam int ROB_W  = 4;
  localparam int LSB_W  = 4;
  localparam int ID_W   = 6;

  localparam logic [ID_W-1:0] ID_SB = 6'd24;
  localparam logic [ID_W-1:0] ID_SH = 6'd25;
  localparam logic [ID_W-1:0] ID_SW = 6'd26;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic              busy;
    logic [ROB_W-1:0]  tag;
    logic [WORD_W-1:0] val;
  } rd_port_t;

  function automatic logic is_store(input logic [ID_W-1:0] id);
    return (id >= ID_SB) && (id <= ID_SW);
  endfunction
endpackage

// File: rtl/commit_unit_if.sv
// ROB/issue-facing bundle of the commit unit; slave = commit unit, master = its environment.
interface commit_unit_if;
  import commit_unit_pkg::*;

  logic              rob_commit_en_in;
  logic [ID_W-1:0]   instr_id_in;
  logic [REG_W-1:0]  rd_in;
  logic [ROB_W-1:0]  rob_pos_in;
  logic [LSB_W-1:0]  lsb_pos_in;
  logic [WORD_W-1:0] res_in;
  logic              jump_en_in;
  logic [ADDR_W-1:0] jump_a_in;
  logic              rename_en_in;
  logic [REG_W-1:0]  rename_rd_in;
  logic [ROB_W-1:0]  rename_rob_pos_in;
  logic [REG_W-1:0]  rs1_idx_in;
  logic [REG_W-1:0]  rs2_idx_in;

  logic              rs1_busy_out;
  logic [ROB_W-1:0]  rs1_rob_pos_out;
  logic [WORD_W-1:0] rs1_val_out;
  logic              rs2_busy_out;
  logic [ROB_W-1:0]  rs2_rob_pos_out;
  logic [WORD_W-1:0] rs2_val_out;
  logic              store_commit_en_out;
  logic [LSB_W-1:0]  store_lsb_pos_out;
  logic              clear_branch_out;
  logic              redirect_en_out;
  logic [ADDR_W-1:0] redirect_pc_out;
  logic [31:0]       commit_cnt_out;

  modport slave (
    input  rob_commit_en_in, instr_id_in, rd_in, rob_pos_in, lsb_pos_in, res_in,
           jump_en_in, jump_a_in, rename_en_in, rename_rd_in, rename_rob_pos_in,
           rs1_idx_in, rs2_idx_in,
    output rs1_busy_out, rs1_rob_pos_out, rs1_val_out, rs2_busy_out, rs2_rob_pos_out,
           rs2_val_out, store_commit_en_out, store_lsb_pos_out, clear_branch_out,
           redirect_en_out, redirect_pc_out, commit_cnt_out
  );

  modport master (
    output rob_commit_en_in, instr_id_in, rd_in, rob_pos_in, lsb_pos_in, res_in,
           jump_en_in, jump_a_in, rename_en_in, rename_rd_in, rename_rob_pos_in,
           rs1_idx_in, rs2_idx_in,
    input  rs1_busy_out, rs1_rob_pos_out, rs1_val_out, rs2_busy_out, rs2_rob_pos_out,
           rs2_val_out, store_commit_en_out, store_lsb_pos_out, clear_branch_out,
           redirect_en_out, redirect_pc_out, commit_cnt_out
  );
endinterface

// File: rtl/regfile_rename.sv
// Architectural regfile with per-register busy/tag rename state and two bypassing read ports.
// Writes land one edge after the request; reads are combinational; rdy_in low freezes everything.
module regfile_rename
  import commit_unit_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              cmt_vld,
  input  logic              wr_vld,
  input  logic [REG_W-1:0]  wr_rd,
  input  logic [ROB_W-1:0]  cmt_tag,
  input  logic [WORD_W-1:0] cmt_dat,
  input  logic              flush,
  input  logic              ren_vld,
  input  logic [REG_W-1:0]  ren_rd,
  input  logic [ROB_W-1:0]  ren_tag,
  input  logic [REG_W-1:0]  rs1_idx,
  input  logic [REG_W-1:0]  rs2_idx,
  output rd_port_t          rs1,
  output rd_port_t          rs2
);
  logic [WORD_W-1:0] val_q [REG_N];
  logic [ROB_W-1:0]  tag_q [REG_N];
  logic [REG_N-1:0]  busy_q;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < REG_N; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (rdy_in) begin
      if (wr_vld && wr_rd != '0) begin
        val_q[wr_rd] <= cmt_dat;
        if (tag_q[wr_rd] == cmt_tag) busy_q[wr_rd] <= 1'b0;
      end
      // A same-cycle rename of the committing rd must win over the busy clear.
      if (ren_vld && ren_rd != '0) begin
        busy_q[ren_rd] <= 1'b1;
        tag_q[ren_rd]  <= ren_tag;
      end
      if (flush) busy_q <= '0;
    end
  end

  function automatic rd_port_t read_port(input logic [REG_W-1:0] idx);
    rd_port_t r;
    r.busy = busy_q[idx];
    r.tag  = tag_q[idx];
    r.val  = val_q[idx];
    if (idx == '0) begin
      r = '0;
    end else if (cmt_vld && busy_q[idx] && tag_q[idx] == cmt_tag) begin
      r.busy = 1'b0;
      r.val  = cmt_dat;
    end
    return r;
  endfunction

  assign rs1 = read_port(rs1_idx);
  assign rs2 = read_port(rs2_idx);
endmodule

// File: rtl/commit_unit.sv
// Retires ROB entries: regfile writeback, store release, branch flush/redirect, retire count.
// Pulse outputs are registered one cycle after the commit; rdy_in low freezes state and zeroes pulses.
module commit_unit
  import commit_unit_pkg::*;
(
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  commit_unit_if.slave bus
);
  state_e state_q, state_d;
  logic   cmt_act, flush_go, st_cmt, wr_vld, ren_vld;

  logic              store_vld_q;
  logic [LSB_W-1:0]  store_pos_q;
  logic              clr_q;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       cnt_q;
  rd_port_t          rs1, rs2;

  always_ff @(posedge clk_in) begin
    if (!rst_in) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cmt_act  = 1'b0;
    flush_go = 1'b0;
    case (state_q)
      ST_RUN: begin
        cmt_act  = rdy_in & bus.rob_commit_en_in;
        flush_go = cmt_act & bus.jump_en_in;
        if (flush_go) state_d = ST_FLUSH;
      end
      ST_FLUSH: if (rdy_in) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  assign st_cmt  = cmt_act & is_store(bus.instr_id_in);
  assign wr_vld  = cmt_act & ~is_store(bus.instr_id_in) & (bus.rd_in != '0);
  assign ren_vld = (state_q == ST_RUN) & bus.rename_en_in;

  // cmt_act already folds in rdy_in, so a stalled cycle naturally drives all pulses to zero.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      store_vld_q <= 1'b0;
      store_pos_q <= '0;
      clr_q       <= 1'b0;
      pc_q        <= '0;
      cnt_q       <= '0;
    end else begin
      store_vld_q <= st_cmt;
      store_pos_q <= st_cmt ? bus.lsb_pos_in : '0;
      clr_q       <= flush_go;
      pc_q        <= flush_go ? bus.jump_a_in : '0;
      if (cmt_act) cnt_q <= cnt_q + 32'd1;
    end
  end

  regfile_rename u_regfile (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rdy_in  (rdy_in),
    .cmt_vld (cmt_act),
    .wr_vld  (wr_vld),
    .wr_rd   (bus.rd_in),
    .cmt_tag (bus.rob_pos_in),
    .cmt_dat (bus.res_in),
    .flush   (flush_go),
    .ren_vld (ren_vld),
    .ren_rd  (bus.rename_rd_in),
    .ren_tag (bus.rename_rob_pos_in),
    .rs1_idx (bus.rs1_idx_in),
    .rs2_idx (bus.rs2_idx_in),
    .rs1     (rs1),
    .rs2     (rs2)
  );

  assign bus.rs1_busy_out        = rs1.busy;
  assign bus.rs1_rob_pos_out     = rs1.tag;
  assign bus.rs1_val_out         = rs1.val;
  assign bus.rs2_busy_out        = rs2.busy;
  assign bus.rs2_rob_pos_out     = rs2.tag;
  assign bus.rs2_val_out         = rs2.val;
  assign bus.store_commit_en_out = store_vld_q;
  assign bus.store_lsb_pos_out   = store_pos_q;
  assign bus.clear_branch_out    = clr_q;
  assign bus.redirect_en_out     = clr_q;
  assign bus.redirect_pc_out     = pc_q;
  assign bus.commit_cnt_out      = cnt_q;
endmodule
